// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan / step-input front end:
// active-low hex segment table, blank pattern and counter width helper.
package seg7_pkg;

    // All segments off (active-low bus, gfedcba).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex digit to active-low segment pattern, bit 0 = a .. bit 6 = g.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000, // 9
        7'b0001000, // A
        7'b0000011, // b
        7'b1000110, // C
        7'b0100001, // d
        7'b0000110, // E
        7'b0001110  // F
    };

    // Decode one hex nibble to its segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

    // Counter width for a modulus of n: clog2(n), never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_step_ctrl_btn_debounce.sv
// Button front end: 2-FF synchroniser, stability counter, debounced level
// and a single-cycle step pulse on each accepted press.
module btn_debounce
    import seg7_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic button,
    output logic btn_level,
    output logic step
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_ff;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          level_next;
    logic          step_next;

    // Count consecutive cycles the synchronised input disagrees with the level; flip on the last one.
    always_comb begin
        cnt_next   = cnt;
        level_next = btn_level;
        step_next  = 1'b0;
        if (enable) begin
            if (sync_ff[1] != btn_level) begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    level_next = ~btn_level;
                    // Only a rising flip (level currently 0) produces a pulse.
                    step_next  = ~btn_level;
                end else begin
                    cnt_next   = cnt + CW'(1);
                end
            end else begin
                cnt_next = '0;
            end
        end else begin
            // Paused: counter and level hold, no pulse.
            cnt_next   = cnt;
            level_next = btn_level;
            step_next  = 1'b0;
        end
    end

    // Synchroniser always runs; debounce state advances only when computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff   <= 2'b00;
            cnt       <= '0;
            btn_level <= 1'b0;
            step      <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[0], button};
            cnt       <= cnt_next;
            btn_level <= level_next;
            step      <= step_next;
        end
    end

endmodule

// File: rtl/seg7_scan_step_ctrl.sv
// N-digit multiplexed 7-segment driver with tear-free frame latching, plus a
// debounced single-step button. Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN - blank zero digits above the highest non-zero
//   digit (digit 0 always shown).
module seg7_scan_step_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  button,
    output logic [6:0]            light,
    output logic [DIGITS-1:0]     en,
    output logic                  step,
    output logic                  btn_level
);

    localparam int PW = cnt_width(SCAN_DIV);
    localparam int IW = cnt_width(DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]       presc;
    logic [PW-1:0]       presc_next;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_next;
    logic [4*DIGITS-1:0] frame;
    logic [4*DIGITS-1:0] frame_next;
    logic [3:0]          nibble;
    logic [DIGITS-1:0]   en_sel;
    logic [DIGITS-1:0]   blank_mask;
    logic                blank_sel;
    logic [6:0]          light_next;
    logic [DIGITS-1:0]   en_next;

    // Prescaler / digit index advance; a new frame is latched only as the index wraps to 0.
    always_comb begin
        presc_next = presc;
        idx_next   = idx;
        frame_next = frame;
        if (enable) begin
            if (presc == PRESC_LAST) begin
                presc_next = '0;
                if (idx == IDX_LAST) begin
                    idx_next   = '0;
                    frame_next = data;
                end else begin
                    idx_next   = idx + IW'(1);
                end
            end else begin
                presc_next = presc + PW'(1);
            end
        end else begin
            presc_next = presc;
            idx_next   = idx;
            frame_next = frame;
        end
    end

    // Mark digits that sit above the highest non-zero digit of the latched frame.
    always_comb begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        logic nz_above;
        nz_above   = 1'b0;
        blank_mask = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz_above      = nz_above | (frame[4*k +: 4] != 4'h0);
            blank_mask[k] = ~nz_above & (k != 0);
        end
`else
        blank_mask = '0;
`endif
    end

    // Select the current digit's nibble, blank flag and one-hot-zero enable.
    always_comb begin
        nibble    = 4'h0;
        blank_sel = 1'b0;
        en_sel    = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nibble    = frame[4*k +: 4];
                blank_sel = blank_mask[k];
                en_sel[k] = 1'b0;
            end else begin
                en_sel[k] = 1'b1;
            end
        end
    end

    // Next values of the registered display outputs.
    always_comb begin
        light_next = SEG_BLANK;
        en_next    = '1;
        if (enable) begin
            en_next    = en_sel;
            light_next = blank_sel ? SEG_BLANK : hex_to_seg(nibble);
        end else begin
            en_next    = '1;
            light_next = SEG_BLANK;
        end
    end

    // Scan state and registered display outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
            frame <= '0;
            light <= SEG_BLANK;
            en    <= '1;
        end else begin
            presc <= presc_next;
            idx   <= idx_next;
            frame <= frame_next;
            light <= light_next;
            en    <= en_next;
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .button    (button),
        .btn_level (btn_level),
        .step      (step)
    );

endmodule
